// File: rtl/redmule_tile_pkg.sv
// Shared definitions for the RedMulE tile: sizes, event-unit register map,
// wake FSM state encoding and CTRL bit positions.
package redmule_tile_pkg;

  localparam int unsigned N_CORE = 1;
  localparam int unsigned N_IRQ  = 32;

  localparam logic [4:0] EVT_UNIT_PENDING_OFFS  = 5'h00;
  localparam logic [4:0] EVT_UNIT_CLEAR_OFFS    = 5'h04;
  localparam logic [4:0] EVT_UNIT_EVT_MASK_OFFS = 5'h08;
  localparam logic [4:0] EVT_UNIT_IRQ_MASK_OFFS = 5'h0C;
  localparam logic [4:0] EVT_UNIT_CTRL_OFFS     = 5'h10;
  localparam logic [4:0] EVT_UNIT_WU_CNT_OFFS   = 5'h14;

  localparam int unsigned EVT_UNIT_CTRL_WFE_EN_BIT   = 0;
  localparam int unsigned EVT_UNIT_CTRL_AUTO_CLR_BIT = 1;

  typedef enum logic [1:0] {
    EVT_UNIT_IDLE  = 2'd0,
    EVT_UNIT_PULSE = 2'd1,
    EVT_UNIT_HOLD  = 2'd2
  } evt_unit_state_e;

endpackage

// File: rtl/redmule_tile_evt_unit_if.sv
// Request/grant register port of the event unit; software side is master.
interface redmule_tile_evt_unit_if;
  logic        req;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/redmule_tile_evt_unit_regs.sv
// Event-unit register file: sticky pending bits with set-over-clear, masks, CTRL,
// registered read mux. Optional WU_CNT under REDMULE_TILE_EVT_UNIT_CNT_EN.
module redmule_tile_evt_unit_regs
  import redmule_tile_pkg::*;
#(
  parameter int unsigned EVT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  redmule_tile_evt_unit_if.slave cfg,
  input  logic [EVT_W-1:0] evt_set,
  input  logic [EVT_W-1:0] auto_clr_mask,
  input  logic             wu_inc,
  output logic [EVT_W-1:0] pending,
  output logic [EVT_W-1:0] evt_mask,
  output logic [EVT_W-1:0] irq_mask,
  output logic             wfe_en,
  output logic             auto_clr
);

  logic [EVT_W-1:0] pending_reg, pending_next;
  logic [EVT_W-1:0] evt_mask_reg, irq_mask_reg;
  logic             wfe_en_reg, auto_clr_reg;
  logic             rvalid_reg;
  logic [31:0]      rdata_reg, rdata_next;
  logic [EVT_W-1:0] clr_vec;
  logic             wr, rd;
  logic             unused_bits;

  assign wr = cfg.req & cfg.we;
  assign rd = cfg.req & ~cfg.we;

  assign cfg.gnt    = cfg.req;
  assign cfg.rvalid = rvalid_reg;
  assign cfg.rdata  = rdata_reg;

  // Set is ORed in after the clear so a same-cycle event always survives.
  assign clr_vec      = ((wr && cfg.addr == EVT_UNIT_CLEAR_OFFS) ? cfg.wdata[EVT_W-1:0] : '0)
                      | auto_clr_mask;
  assign pending_next = (pending_reg & ~clr_vec) | evt_set;

`ifdef REDMULE_TILE_EVT_UNIT_CNT_EN
  logic [31:0] wu_cnt_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wu_cnt_reg <= '0;
    end else if (wr && cfg.addr == EVT_UNIT_WU_CNT_OFFS) begin
      wu_cnt_reg <= '0;
    end else if (wu_inc && wu_cnt_reg != 32'hFFFF_FFFF) begin
      wu_cnt_reg <= wu_cnt_reg + 32'd1;
    end
  end

  assign unused_bits = ^cfg.wdata;
`else
  assign unused_bits = ^{cfg.wdata, wu_inc};
`endif

  always_comb begin
    rdata_next = '0;
    case (cfg.addr)
      EVT_UNIT_PENDING_OFFS:  rdata_next = 32'(pending_reg);
      EVT_UNIT_EVT_MASK_OFFS: rdata_next = 32'(evt_mask_reg);
      EVT_UNIT_IRQ_MASK_OFFS: rdata_next = 32'(irq_mask_reg);
      EVT_UNIT_CTRL_OFFS: begin
        rdata_next[EVT_UNIT_CTRL_WFE_EN_BIT]   = wfe_en_reg;
        rdata_next[EVT_UNIT_CTRL_AUTO_CLR_BIT] = auto_clr_reg;
      end
`ifdef REDMULE_TILE_EVT_UNIT_CNT_EN
      EVT_UNIT_WU_CNT_OFFS:   rdata_next = wu_cnt_reg;
`endif
      default:                rdata_next = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_reg  <= '0;
      evt_mask_reg <= '0;
      irq_mask_reg <= '0;
      wfe_en_reg   <= 1'b0;
      auto_clr_reg <= 1'b0;
      rvalid_reg   <= 1'b0;
      rdata_reg    <= '0;
    end else begin
      pending_reg <= pending_next;
      if (wr && cfg.addr == EVT_UNIT_EVT_MASK_OFFS) evt_mask_reg <= cfg.wdata[EVT_W-1:0];
      if (wr && cfg.addr == EVT_UNIT_IRQ_MASK_OFFS) irq_mask_reg <= cfg.wdata[EVT_W-1:0];
      if (wr && cfg.addr == EVT_UNIT_CTRL_OFFS) begin
        wfe_en_reg   <= cfg.wdata[EVT_UNIT_CTRL_WFE_EN_BIT];
        auto_clr_reg <= cfg.wdata[EVT_UNIT_CTRL_AUTO_CLR_BIT];
      end
      rvalid_reg <= cfg.req;
      rdata_reg  <= rd ? rdata_next : '0;
    end
  end

  assign pending  = pending_reg;
  assign evt_mask = evt_mask_reg;
  assign irq_mask = irq_mask_reg;
  assign wfe_en   = wfe_en_reg;
  assign auto_clr = auto_clr_reg;

endmodule

// File: rtl/redmule_tile_evt_unit.sv
// RedMulE tile event/wake-up controller: busy falling-edge detect, wake FSM and
// IRQ mapping. Optional wake counter via REDMULE_TILE_EVT_UNIT_CNT_EN.
module redmule_tile_evt_unit
  import redmule_tile_pkg::*;
#(
  parameter int unsigned N_CORE     = redmule_tile_pkg::N_CORE,
  parameter int unsigned N_IRQ      = redmule_tile_pkg::N_IRQ,
  parameter int unsigned IRQ_OFFSET = 16,
  parameter int unsigned WU_CYCLES  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_CORE-1:0][1:0] evt_i,
  input  logic                   busy_i,
  input  logic                   core_sleep_i,
  redmule_tile_evt_unit_if.slave cfg,
  output logic [N_IRQ-1:0]       irq_o,
  output logic                   wu_wfe_o
);

  localparam int unsigned EVT_W = 2 * N_CORE + 1;
  localparam int unsigned CNT_W = (WU_CYCLES > 1) ? $clog2(WU_CYCLES) : 1;
  localparam logic [CNT_W-1:0] WU_LOAD = CNT_W'(WU_CYCLES - 1);

  if (IRQ_OFFSET + EVT_W > N_IRQ) begin : g_bad_irq_offset
    $error("redmule_tile_evt_unit: IRQ_OFFSET+EVT_W exceeds N_IRQ");
  end
  if (WU_CYCLES < 1) begin : g_bad_wu_cycles
    $error("redmule_tile_evt_unit: WU_CYCLES must be at least 1");
  end
  if (EVT_W > 32) begin : g_bad_evt_w
    $error("redmule_tile_evt_unit: event vector wider than a register");
  end

  logic [EVT_W-1:0] evt_vec;
  logic [EVT_W-1:0] pending, evt_mask, irq_mask, auto_clr_mask;
  logic             wfe_en, auto_clr, wu_inc, wake_hit;
  logic             busy_q;
  evt_unit_state_e  state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [N_IRQ-1:0] irq_reg;

  for (genvar gi = 0; gi < N_CORE; gi++) begin : g_evt
    assign evt_vec[2*gi]   = evt_i[gi][0];
    assign evt_vec[2*gi+1] = evt_i[gi][1];
  end
  assign evt_vec[EVT_W-1] = busy_q & ~busy_i;

  redmule_tile_evt_unit_regs #(
    .EVT_W (EVT_W)
  ) i_regs (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .cfg           (cfg),
    .evt_set       (evt_vec),
    .auto_clr_mask (auto_clr_mask),
    .wu_inc        (wu_inc),
    .pending       (pending),
    .evt_mask      (evt_mask),
    .irq_mask      (irq_mask),
    .wfe_en        (wfe_en),
    .auto_clr      (auto_clr)
  );

  assign wake_hit = wfe_en & core_sleep_i & (|(pending & evt_mask));

  // HOLD waits for the core to leave sleep so one sleep period wakes only once.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    wu_inc        = 1'b0;
    auto_clr_mask = '0;
    case (state_reg)
      EVT_UNIT_IDLE: begin
        if (wake_hit) begin
          state_next = EVT_UNIT_PULSE;
          cnt_next   = WU_LOAD;
          wu_inc     = 1'b1;
          if (auto_clr) auto_clr_mask = pending & evt_mask;
        end
      end
      EVT_UNIT_PULSE: begin
        if (cnt_reg == '0) state_next = EVT_UNIT_HOLD;
        else               cnt_next   = cnt_reg - CNT_W'(1);
      end
      EVT_UNIT_HOLD: begin
        if (!core_sleep_i) state_next = EVT_UNIT_IDLE;
      end
      default: state_next = EVT_UNIT_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q    <= 1'b0;
      state_reg <= EVT_UNIT_IDLE;
      cnt_reg   <= '0;
      irq_reg   <= '0;
    end else begin
      busy_q    <= busy_i;
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      irq_reg   <= N_IRQ'(pending & irq_mask) << IRQ_OFFSET;
    end
  end

  assign irq_o    = irq_reg;
  assign wu_wfe_o = (state_reg == EVT_UNIT_PULSE);

endmodule

// File: tb/tb_redmule_tile_evt_unit.sv
// Directed self-checking bench for redmule_tile_evt_unit (N_CORE=1, WU_CYCLES=4).
module tb_redmule_tile_evt_unit;
  import redmule_tile_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  logic [0:0][1:0] evt;
  logic           busy;
  logic           sleep;
  logic [31:0]    irq;
  logic           wu;
  logic [31:0]    rd_data;
  int             checks = 0;
  int             errors = 0;
  int             highs, first;

  redmule_tile_evt_unit_if cfg_if ();

  redmule_tile_evt_unit #(
    .N_CORE     (1),
    .N_IRQ      (32),
    .IRQ_OFFSET (16),
    .WU_CYCLES  (4)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .evt_i        (evt),
    .busy_i       (busy),
    .core_sleep_i (sleep),
    .cfg          (cfg_if),
    .irq_o        (irq),
    .wu_wfe_o     (wu)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [4:0] addr, input logic [31:0] data);
    cfg_if.req = 1'b1; cfg_if.we = 1'b1; cfg_if.addr = addr; cfg_if.wdata = data;
    #1 check("wr_gnt", 32'(cfg_if.gnt), 32'd1);
    tick();
    cfg_if.req = 1'b0; cfg_if.we = 1'b0;
    check("wr_rvalid", 32'(cfg_if.rvalid), 32'd1);
    $display("wr addr=%h data=%h", addr, data);
  endtask

  task automatic cfg_read(input logic [4:0] addr, output logic [31:0] data);
    cfg_if.req = 1'b1; cfg_if.we = 1'b0; cfg_if.addr = addr;
    tick();
    cfg_if.req = 1'b0;
    check("rd_rvalid", 32'(cfg_if.rvalid), 32'd1);
    data = cfg_if.rdata;
    $display("rd addr=%h data=%h", addr, data);
  endtask

  task automatic check_read(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    cfg_read(addr, d);
    check(tag, d, exp);
  endtask

  task automatic count_wu(input int n, output int h, output int f);
    h = 0;
    f = -1;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (wu) begin
        h++;
        if (f < 0) f = i;
      end
    end
  endtask

  initial begin
    rst = 1'b1; evt = '0; busy = 1'b0; sleep = 1'b0;
    cfg_if.req = 1'b0; cfg_if.we = 1'b0; cfg_if.addr = '0; cfg_if.wdata = '0;
    tick(); tick();
    check("rst_irq", irq, 32'd0);
    check("rst_wu", 32'(wu), 32'd0);
    check("rst_gnt", 32'(cfg_if.gnt), 32'd0);
    check("rst_rvalid", 32'(cfg_if.rvalid), 32'd0);
    check("rst_rdata", cfg_if.rdata, 32'd0);
    rst = 1'b0;
    tick();

    for (int a = 0; a < 6; a++) check_read($sformatf("rst_rd_%0h", a * 4), 5'(a * 4), 32'd0);

    // IRQ path: event -> pending (1 cycle) -> irq (2 cycles)
    cfg_write(EVT_UNIT_IRQ_MASK_OFFS, 32'd1);
    evt = 2'b01;
    tick();
    evt = '0;
    check("irq_lat1", irq, 32'd0);
    tick();
    check("irq_rise", irq, 32'h0001_0000);
    tick();
    check("irq_hold", irq, 32'h0001_0000);
    cfg_write(EVT_UNIT_CLEAR_OFFS, 32'd1);
    check("irq_clr_edge", irq, 32'h0001_0000);
    tick();
    check("irq_fall", irq, 32'd0);
    check_read("pend_cleared", EVT_UNIT_PENDING_OFFS, 32'd0);
    cfg_write(EVT_UNIT_IRQ_MASK_OFFS, 32'd0);

    // Wake on busy falling edge, no auto clear
    cfg_write(EVT_UNIT_EVT_MASK_OFFS, 32'd4);
    cfg_write(EVT_UNIT_CTRL_OFFS, 32'd1);
    busy = 1'b1; sleep = 1'b1;
    tick(); tick();
    busy = 1'b0;
    count_wu(10, highs, first);
    check("wake_width", 32'(highs), 32'd4);
    check("wake_latency", 32'(first), 32'd2);
    check_read("wake_pending", EVT_UNIT_PENDING_OFFS, 32'd4);
    count_wu(6, highs, first);
    check("no_retrigger", 32'(highs), 32'd0);
    sleep = 1'b0;
    tick();
    sleep = 1'b1;
    count_wu(8, highs, first);
    check("rewake_width", 32'(highs), 32'd4);
    check("rewake_latency", 32'(first), 32'd1);
    cfg_write(EVT_UNIT_CLEAR_OFFS, 32'd4);
    sleep = 1'b0;
    tick();

    // Wake with auto clear
    cfg_write(EVT_UNIT_CTRL_OFFS, 32'd3);
    busy = 1'b1;
    tick(); tick();
    sleep = 1'b1; busy = 1'b0;
    count_wu(8, highs, first);
    check("aclr_width", 32'(highs), 32'd4);
    check("aclr_latency", 32'(first), 32'd2);
    check_read("aclr_pending", EVT_UNIT_PENDING_OFFS, 32'd0);
    sleep = 1'b0;
    tick();
    sleep = 1'b1;
    count_wu(8, highs, first);
    check("aclr_no_second", 32'(highs), 32'd0);
    sleep = 1'b0; busy = 1'b1;
    tick();

    // Set/clear collision and read-before-set
    cfg_write(EVT_UNIT_CTRL_OFFS, 32'd0);
    cfg_if.req = 1'b1; cfg_if.we = 1'b1; cfg_if.addr = EVT_UNIT_CLEAR_OFFS; cfg_if.wdata = 32'd1;
    evt = 2'b01;
    tick();
    cfg_if.req = 1'b0; cfg_if.we = 1'b0; evt = '0;
    $display("wr addr=%h data=%h with evt", EVT_UNIT_CLEAR_OFFS, 32'd1);
    check_read("set_wins", EVT_UNIT_PENDING_OFFS, 32'd1);
    cfg_if.req = 1'b1; cfg_if.we = 1'b0; cfg_if.addr = EVT_UNIT_PENDING_OFFS;
    evt = 2'b10;
    tick();
    cfg_if.req = 1'b0; evt = '0;
    check("read_before_set", cfg_if.rdata, 32'd1);
    $display("rd addr=%h data=%h with evt", EVT_UNIT_PENDING_OFFS, cfg_if.rdata);
    check_read("pend_after_set", EVT_UNIT_PENDING_OFFS, 32'd3);
    check_read("clear_reads0", EVT_UNIT_CLEAR_OFFS, 32'd0);
    check_read("evt_mask_rb", EVT_UNIT_EVT_MASK_OFFS, 32'd4);
    check_read("ctrl_rb", EVT_UNIT_CTRL_OFFS, 32'd0);
    cfg_write(EVT_UNIT_CLEAR_OFFS, 32'hFFFF_FFFF);
    check_read("clear_all", EVT_UNIT_PENDING_OFFS, 32'd0);
    cfg_write(5'h18, 32'hFF);
    check_read("unmapped_rd", 5'h18, 32'd0);
    check_read("unmapped_wr", EVT_UNIT_EVT_MASK_OFFS, 32'd4);
    cfg_write(EVT_UNIT_CTRL_OFFS, 32'hFFFF_FFFC);
    check_read("ctrl_bits", EVT_UNIT_CTRL_OFFS, 32'd0);

`ifdef REDMULE_TILE_EVT_UNIT_CNT_EN
    check_read("wu_cnt", EVT_UNIT_WU_CNT_OFFS, 32'd3);
    cfg_write(EVT_UNIT_WU_CNT_OFFS, 32'd5);
    check_read("wu_cnt_clr", EVT_UNIT_WU_CNT_OFFS, 32'd0);
`else
    check_read("wu_cnt_off", EVT_UNIT_WU_CNT_OFFS, 32'd0);
    cfg_write(EVT_UNIT_WU_CNT_OFFS, 32'hFFFF_FFFF);
    check_read("wu_cnt_off_wr", EVT_UNIT_WU_CNT_OFFS, 32'd0);
`endif

    // Asynchronous reset in the middle of a pulse
    cfg_write(EVT_UNIT_EVT_MASK_OFFS, 32'd1);
    cfg_write(EVT_UNIT_CTRL_OFFS, 32'd1);
    sleep = 1'b1;
    evt = 2'b01;
    tick();
    evt = '0;
    tick();
    check("pre_rst_pulse", 32'(wu), 32'd1);
    #2 rst = 1'b1;
    #1 check("async_rst_wu", 32'(wu), 32'd0);
    tick();
    rst = 1'b0;
    check_read("post_rst_pend", EVT_UNIT_PENDING_OFFS, 32'd0);
    check_read("post_rst_ctrl", EVT_UNIT_CTRL_OFFS, 32'd0);
    count_wu(4, highs, first);
    check("post_rst_no_wu", 32'(highs), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
